// File: rtl/cond_code_unit_pkg.sv
// Y86 constants shared by decode, ALU and condition-code logic:
// condition function encodings, CC bit positions and the CC reset value.
package cond_code_unit_pkg;

    typedef enum logic [3:0] {
        IFUN_ALWAYS = 4'd0,
        IFUN_LE     = 4'd1,
        IFUN_L      = 4'd2,
        IFUN_E      = 4'd3,
        IFUN_NE     = 4'd4,
        IFUN_GE     = 4'd5,
        IFUN_G      = 4'd6
    } ifun_e;

    localparam int CC_OF = 0;
    localparam int CC_ZF = 1;
    localparam int CC_SF = 2;

    localparam logic [2:0] CC_RESET_VAL = 3'b010;

    localparam logic [3:0] IFUN_MAX = 4'd6;

    function automatic logic ifun_is_bad(input logic [3:0] ifun);
        return ifun > IFUN_MAX;
    endfunction

endpackage

// File: rtl/cond_code_unit_if.sv
// Execute-stage bundle between pipeline control and the condition-code unit.
// master drives flags/control and observes results; slave is the unit itself.
interface cond_code_unit_if;
    logic [2:0] alu_cf;
    logic       set_cc;
    logic       exc_pending;
    logic       valid_in;
    logic [3:0] ifun;
    logic       stall;
    logic       bubble;
    logic [2:0] cc_out;
    logic       cnd_out;
    logic       valid_out;
    logic       bad_ifun;

    modport master (
        output alu_cf, set_cc, exc_pending, valid_in, ifun, stall, bubble,
        input  cc_out, cnd_out, valid_out, bad_ifun
    );

    modport slave (
        input  alu_cf, set_cc, exc_pending, valid_in, ifun, stall, bubble,
        output cc_out, cnd_out, valid_out, bad_ifun
    );
endinterface

// File: rtl/cond_code_unit_cond_eval.sv
// Combinational Y86 condition evaluator: cc + ifun -> cnd, bad (ifun out of range).
// Latency 0; no flow control, pure function of its inputs.
module cond_eval
    import cond_code_unit_pkg::*;
(
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd,
    output logic       bad
);
    logic of_f, zf_f, sf_f, lt;

    always_comb begin
        of_f = cc[CC_OF];
        zf_f = cc[CC_ZF];
        sf_f = cc[CC_SF];
        lt   = sf_f ^ of_f;
        bad  = ifun_is_bad(ifun);
        cnd  = 1'b0;
        case (ifun)
            IFUN_ALWAYS: cnd = 1'b1;
            IFUN_LE:     cnd = lt | zf_f;
            IFUN_L:      cnd = lt;
            IFUN_E:      cnd = zf_f;
            IFUN_NE:     cnd = ~zf_f;
            IFUN_GE:     cnd = ~lt;
            IFUN_G:      cnd = ~lt & ~zf_f;
            default:     cnd = 1'b0;
        endcase
    end
endmodule

// File: rtl/cond_code_unit.sv
// Condition-code register plus registered condition result for the execute stage.
// Latency 1 cycle; stall freezes all state (beats bubble), bubble clears the result.
module cond_code_unit
    import cond_code_unit_pkg::*;
#(
    parameter logic [2:0] CC_RESET = CC_RESET_VAL
) (
    input  logic             clk,
    input  logic             rst_n,
    cond_code_unit_if.slave  bus
);
    logic [2:0] cc_q, cc_d;
    logic       cnd_q, cnd_d;
    logic       valid_q, valid_d;
    logic       bad_q, bad_d;
    logic       eval_cnd, eval_bad;

    // Evaluated against the registered CC, so a same-cycle set_cc sees old flags.
    cond_eval u_eval (
        .cc   (cc_q),
        .ifun (bus.ifun),
        .cnd  (eval_cnd),
        .bad  (eval_bad)
    );

    always_comb begin
        cc_d    = cc_q;
        cnd_d   = cnd_q;
        valid_d = valid_q;
        bad_d   = bad_q;
        if (!bus.stall) begin
            if (bus.set_cc && bus.valid_in && !bus.exc_pending) begin
                cc_d = bus.alu_cf;
            end
            if (bus.bubble) begin
                cnd_d   = 1'b0;
                valid_d = 1'b0;
                bad_d   = 1'b0;
            end else begin
                cnd_d   = bus.valid_in & eval_cnd;
                valid_d = bus.valid_in;
                bad_d   = bus.valid_in & eval_bad;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cc_q    <= CC_RESET;
            cnd_q   <= 1'b0;
            valid_q <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            cc_q    <= cc_d;
            cnd_q   <= cnd_d;
            valid_q <= valid_d;
            bad_q   <= bad_d;
        end
    end

    assign bus.cc_out    = cc_q;
    assign bus.cnd_out   = cnd_q;
    assign bus.valid_out = valid_q;
    assign bus.bad_ifun  = bad_q;
endmodule

// File: tb/tb_cond_code_unit.sv
// Bench for cond_code_unit: reference model of the flag rules, per-cycle compare,
// directed scenarios with literal expectations, exhaustive table and random traffic.
module tb_cond_code_unit;
    logic clk = 1'b0;
    logic rst_n;
    cond_code_unit_if bus ();

    cond_code_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [2:0] m_cc;
    bit m_cnd, m_vld, m_bad, m_known = 1'b0;

    function automatic bit ref_cond(input logic [2:0] cc, input int f);
        bit of_b = cc[0];
        bit zf_b = cc[1];
        bit sf_b = cc[2];
        bit less = (sf_b != of_b);
        case (f)
            0: return 1'b1;
            1: return less || zf_b;
            2: return less;
            3: return zf_b;
            4: return !zf_b;
            5: return !less;
            6: return !less && !zf_b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one update per rising edge from the driven inputs.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_cc = 3'b010; m_cnd = 0; m_vld = 0; m_bad = 0; m_known = 1;
        end else if (m_known && !bus.stall) begin
            bit c;
            c = ref_cond(m_cc, int'(bus.ifun));
            if (bus.bubble) begin
                m_cnd = 0; m_vld = 0; m_bad = 0;
            end else begin
                m_vld = bus.valid_in;
                m_cnd = bus.valid_in && c;
                m_bad = bus.valid_in && (bus.ifun > 4'd6);
            end
            if (bus.set_cc && bus.valid_in && !bus.exc_pending) m_cc = bus.alu_cf;
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("cc_out",    int'(bus.cc_out),    int'(m_cc));
            chk("cnd_out",   int'(bus.cnd_out),   int'(m_cnd));
            chk("valid_out", int'(bus.valid_out), int'(m_vld));
            chk("bad_ifun",  int'(bus.bad_ifun),  int'(m_bad));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.alu_cf = 3'b000; bus.set_cc = 0; bus.exc_pending = 0;
        bus.valid_in = 0; bus.ifun = 4'd0; bus.stall = 0; bus.bubble = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        cyc();
        chk("rst_cc", int'(bus.cc_out), 3'b010);
        chk("rst_valid", int'(bus.valid_out), 0);
        chk("rst_bad", int'(bus.bad_ifun), 0);

        rst_n = 1'b1; bus.valid_in = 1; bus.ifun = 4'd3;
        cyc();
        chk("first_e", int'(bus.cnd_out), 1);

        bus.set_cc = 1; bus.alu_cf = 3'b101; bus.ifun = 4'd2;
        cyc();
        chk("old_cc_l", int'(bus.cnd_out), 0);
        chk("cc_loaded", int'(bus.cc_out), 3'b101);
        bus.set_cc = 0; bus.ifun = 4'd2;
        cyc();
        chk("new_cc_l", int'(bus.cnd_out), 0);
        bus.ifun = 4'd5;
        cyc();
        chk("new_cc_ge", int'(bus.cnd_out), 1);

        rst_n = 0;
        cyc();
        rst_n = 1; bus.exc_pending = 1; bus.set_cc = 1; bus.alu_cf = 3'b100;
        cyc();
        chk("exc_suppress", int'(bus.cc_out), 3'b010);
        bus.exc_pending = 0; bus.set_cc = 0;

        bus.ifun = 4'd3;
        cyc();
        bus.stall = 1; bus.bubble = 1; bus.ifun = 4'd4; bus.set_cc = 1; bus.alu_cf = 3'b000;
        cyc();
        cyc();
        chk("stall_cnd", int'(bus.cnd_out), 1);
        chk("stall_vld", int'(bus.valid_out), 1);
        chk("stall_cc", int'(bus.cc_out), 3'b010);
        bus.stall = 0; bus.set_cc = 0;
        cyc();
        chk("bubble_vld", int'(bus.valid_out), 0);
        chk("bubble_cnd", int'(bus.cnd_out), 0);

        bus.bubble = 0; bus.ifun = 4'd9; bus.valid_in = 1;
        cyc();
        chk("bad_cnd", int'(bus.cnd_out), 0);
        chk("bad_flag", int'(bus.bad_ifun), 1);
        chk("bad_vld", int'(bus.valid_out), 1);

        // Reset arriving with a capture pending must drop it and restore CC_RESET.
        bus.set_cc = 1; bus.alu_cf = 3'b101; bus.ifun = 4'd0;
        cyc();
        bus.set_cc = 0; rst_n = 0; bus.ifun = 4'd3;
        cyc();
        chk("rst_mid_vld", int'(bus.valid_out), 0);
        rst_n = 1;
        cyc();
        chk("post_rst_e", int'(bus.cnd_out), 1);

        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 7; f++) begin
                bus.valid_in = 1; bus.set_cc = 1; bus.alu_cf = 3'(c); bus.ifun = 4'd0;
                cyc();
                bus.set_cc = 0; bus.ifun = 4'(f);
                cyc();
            end
        end

        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            bus.alu_cf = 3'($urandom_range(0, 7));
            bus.set_cc = 1'($urandom_range(0, 1));
            bus.exc_pending = ($urandom_range(0, 3) == 0);
            bus.valid_in = ($urandom_range(0, 4) != 0);
            bus.ifun = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(7, 15))
                                                   : 4'($urandom_range(0, 6));
            bus.stall = ($urandom_range(0, 4) == 0);
            bus.bubble = ($urandom_range(0, 5) == 0);
            cyc();
        end

        idle();
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cond_code_unit.md
COND_CODE_UNIT -- requirements
Module: cond_code_unit

Interface
REQ-001 SHALL have parameter CC_RESET, default 3'b010, the condition-code value loaded at reset: bit0=OF, bit1=ZF, bit2=SF.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port alu_cf, input, 3, ALU flags: bit0=OF, bit1=ZF, bit2=SF.
REQ-005 SHALL have port set_cc, input, 1, request to load alu_cf into the CC register (an OPq in execute).
REQ-006 SHALL have port exc_pending, input, 1, exception pending in a later stage; suppresses the CC update.
REQ-007 SHALL have port valid_in, input, 1, an instruction is present in execute.
REQ-008 SHALL have port ifun, input, 4, condition function code.
REQ-009 SHALL have port stall, input, 1, hold the output register.
REQ-010 SHALL have port bubble, input, 1, insert a bubble into the output register.
REQ-011 SHALL have port cc_out, output, 3, current CC register, same bit order as alu_cf.
REQ-012 SHALL have port cnd_out, output, 1, registered condition result.
REQ-013 SHALL have port valid_out, output, 1, cnd_out holds a live result.
REQ-014 SHALL have port bad_ifun, output, 1, registered flag: ifun was greater than 6 for the captured instruction.

Function
REQ-015 SHALL evaluate the combinational condition from cc_out as it was before this cycle's update:
  - ifun 0: 1
  - ifun 1 (le): (SF^OF)|ZF
  - ifun 2 (l): SF^OF
  - ifun 3 (e): ZF
  - ifun 4 (ne): !ZF
  - ifun 5 (ge): !(SF^OF)
  - ifun 6 (g): !(SF^OF)&!ZF
REQ-016 SHALL, for ifun 7..15, evaluate the condition as 0 with bad_ifun=1 at capture.
REQ-017 SHALL load alu_cf into the CC register when set_cc=1, valid_in=1, exc_pending=0 and stall=0; otherwise the CC register holds.
REQ-018 SHALL capture the condition, bad_ifun and valid_in into the output register when stall=0 and bubble=0; latency is 1 cycle.
REQ-019 SHALL clear valid_out, cnd_out and bad_ifun on a cycle with bubble=1 and stall=0.
REQ-020 SHALL hold all registers when stall=1, regardless of bubble; stall has priority over bubble.
REQ-021 SHALL, when set_cc=1 and the condition is evaluated in the same cycle, use the old CC; the new CC is visible the next cycle.
REQ-022 SHALL capture cnd_out=0 and bad_ifun=0 when valid_in=0 (with no stall or bubble).
REQ-023 SHALL have no combinational path from any input to any output.

Reset
REQ-024 SHALL, when rst_n=0 at a clock edge, set cc_out=CC_RESET, cnd_out=0, valid_out=0 and bad_ifun=0, overriding stall, bubble and set_cc.
REQ-025 SHALL make reset asserted mid-operation discard a pending capture; the first post-reset evaluation SHALL use CC_RESET.

Structure
REQ-026 SHALL take the ifun encodings (ALWAYS..G), the CC bit indices (OF=0, ZF=1, SF=2) and the CC_RESET value from a shared Y86 constants package also used by the decode and ALU blocks.
REQ-027 SHALL implement the combinational evaluator as one sub-module, cond_eval (inputs cc[2:0] and ifun[3:0]; outputs cnd and bad); the top level holds only registers and control.

Verification
REQ-028 SHALL verify reset: rst_n=0 for 1 cycle -> cc_out=3'b010, valid_out=0; then ifun=3 with valid_in=1 -> cnd_out=1 next cycle.
REQ-029 SHALL verify CC load and ordering: set_cc=1, alu_cf=3'b101 (SF=1, OF=1) with ifun=2 in the same cycle -> cnd_out=0 (old CC); next cycle ifun=2 -> cnd_out=0 and ifun=5 -> cnd_out=1.
REQ-030 SHALL verify exception suppression: exc_pending=1 with set_cc=1 and alu_cf=3'b100 -> cc_out unchanged at 3'b010.
REQ-031 SHALL verify stall/bubble priority: stall=1 and bubble=1 together for 2 cycles -> all outputs frozen; then bubble alone -> valid_out=0 and cnd_out=0.
REQ-032 SHALL verify illegal ifun: ifun=9, valid_in=1 -> cnd_out=0, bad_ifun=1, valid_out=1.
REQ-033 SHALL verify exhaustively: all 8 CC values × ifun 0..6 checked against the REQ-015 table.
